// File: rtl/bram_stream_reader.sv
// Read-side controller for the dual-port block RAM: walks a contiguous (wrapping)
// address range and emits the words as a valid/ready stream with last marking.
module bram_stream_reader #(
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_en,
    input  logic [DATA_BITS-1:0] mem_data,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_BITS:0]   CNT_ONE  = 1;

    state_t                state;
    logic [ADDR_BITS:0]    issue_cnt;
    logic [ADDR_BITS:0]    pop_cnt;
    logic                  inflight;
    logic [DATA_BITS-1:0]  fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  pop;
    logic [2:0]            credit;

    assign pop     = m_valid && m_ready;
    // Occupancy after this edge if nothing new were issued; the in-flight word
    // already holds a slot, so at most two words are ever owed to the FIFO.
    assign credit  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign mem_en  = (state == READ) && (issue_cnt != '0) && (credit < 3'd2);
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (pop_cnt == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            inflight <= mem_en;
            done     <= 1'b0;

            if (inflight) begin
                fifo_mem[wr_ptr] <= mem_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};

            if (mem_en) begin
                mem_addr  <= mem_addr + ADDR_ONE;
                issue_cnt <= issue_cnt - CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            mem_addr  <= base_addr;
                            issue_cnt <= length;
                            pop_cnt   <= length;
                            state     <= READ;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (pop) begin
                        pop_cnt <= pop_cnt - CNT_ONE;
                        if (pop_cnt == CNT_ONE) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a registered-read RAM model.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] length;
    logic        busy, done, mem_en, m_valid, m_ready, m_last;
    logic [10:0] mem_addr;
    logic [15:0] mem_data = 16'h0;
    logic [15:0] m_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] ram [2048];

    logic [15:0] dq[$];
    bit          lq[$];
    logic [10:0] aq[$];
    int first_en, first_valid, last_hs, done_cyc, busy_cyc, valid_cyc;
    int stab_err, credit_err, last_bad, busy_after, done_after;

    bram_stream_reader #(.ADDR_BITS(11), .DATA_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en),
        .mem_data(mem_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_data <= ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transfer; cycle k is the cycle following the k-th edge after the start edge.
    task automatic xfer(input logic [10:0] b, input logic [11:0] n, input bit rnd);
        int cyc, issued, popped;
        bit prev_stall, hs;
        logic [15:0] prev_d;
        dq.delete(); lq.delete(); aq.delete();
        first_en = -1; first_valid = -1; last_hs = -1; done_cyc = -1;
        busy_cyc = 0; valid_cyc = 0; stab_err = 0; credit_err = 0; last_bad = 0;
        issued = 0; popped = 0; prev_stall = 0; prev_d = '0; cyc = 0;
        @(negedge clk);
        base_addr = b; length = n; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (done_cyc < 0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            hs = m_valid && m_ready;
            if (busy) busy_cyc++;
            if (m_valid) begin
                valid_cyc++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (m_last && !m_valid) last_bad++;
            if (prev_stall && m_data !== prev_d) stab_err++;
            if (issued - popped + int'(mem_en) - int'(hs) > 2) credit_err++;
            if (mem_en) begin
                aq.push_back(mem_addr);
                issued++;
                if (first_en < 0) first_en = cyc;
            end
            if (hs) begin
                dq.push_back(m_data);
                lq.push_back(m_last);
                popped++;
                last_hs = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            if (done) done_cyc = cyc;
        end
        if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    function automatic int last_count();
        int c = 0;
        foreach (lq[i]) if (lq[i]) c++;
        return c;
    endfunction

    initial begin
        logic [15:0] exp_basic [4];
        int errs, dup, done_seen, hs, guard;
        bit pulsed;
        bit seen [2048];

        for (int i = 0; i < 2048; i++) ram[i] = 16'((i * 40503) ^ 32'h5A5A);
        ram[10] = 16'h00A0; ram[11] = 16'h00A1; ram[12] = 16'h00A2; ram[13] = 16'h00A3;
        exp_basic[0] = 16'h00A0; exp_basic[1] = 16'h00A1;
        exp_basic[2] = 16'h00A2; exp_basic[3] = 16'h00A3;

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic burst
        xfer(11'd10, 12'd4, 1'b0);
        chk("basic_words", dq.size(), 4);
        foreach (dq[i]) chk($sformatf("basic_data%0d", i), dq[i], exp_basic[i]);
        chk("basic_last_pos", lq[lq.size()-1], 1);
        chk("basic_last_cnt", last_count(), 1);
        chk("basic_first_en", first_en, 1);
        chk("basic_first_addr", aq[0], 10);
        chk("basic_first_valid", first_valid, 3);
        chk("basic_valid_cyc", valid_cyc, 4);
        chk("basic_last_hs", last_hs, 6);
        chk("basic_done_cyc", done_cyc, 7);
        chk("basic_busy_cyc", busy_cyc, 7);
        chk("basic_busy_after", busy_after, 0);
        chk("basic_done_after", done_after, 0);

        // backpressure
        xfer(11'd10, 12'd4, 1'b1);
        chk("bp_words", dq.size(), 4);
        foreach (dq[i]) chk($sformatf("bp_data%0d", i), dq[i], exp_basic[i]);
        chk("bp_last_pos", lq[lq.size()-1], 1);
        chk("bp_last_cnt", last_count(), 1);
        chk("bp_stable", stab_err, 0);
        chk("bp_credit", credit_err, 0);
        chk("bp_last_bad", last_bad, 0);

        // wrap-around
        xfer(11'd2046, 12'd4, 1'b0);
        chk("wrap_issues", aq.size(), 4);
        chk("wrap_addr0", aq[0], 2046);
        chk("wrap_addr1", aq[1], 2047);
        chk("wrap_addr2", aq[2], 0);
        chk("wrap_addr3", aq[3], 1);
        chk("wrap_words", dq.size(), 4);
        chk("wrap_data0", dq[0], ram[2046]);
        chk("wrap_data1", dq[1], ram[2047]);
        chk("wrap_data2", dq[2], ram[0]);
        chk("wrap_data3", dq[3], ram[1]);
        chk("wrap_last", lq[3], 1);
        chk("wrap_last_cnt", last_count(), 1);

        // zero length
        xfer(11'd32, 12'd0, 1'b0);
        chk("zero_mem_en", aq.size(), 0);
        chk("zero_valid", valid_cyc, 0);
        chk("zero_busy_cyc", busy_cyc, 1);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_busy_after", busy_after, 0);

        // reset mid-transfer with an ignored second start
        dq.delete();
        done_seen = 0; hs = 0; guard = 0; pulsed = 0;
        @(negedge clk);
        base_addr = 11'd100; length = 12'd8; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (hs < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            start = 1'b0;
            m_ready = 1'b1;
            #1;
            if (done) done_seen++;
            if (m_valid && m_ready) begin
                dq.push_back(m_data);
                hs++;
            end
            if (hs == 2 && !pulsed) begin
                pulsed = 1;
                base_addr = 11'd500; length = 12'd3; start = 1'b1;
            end
        end
        start = 1'b0;
        chk("mid_words", dq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("mid_data%0d", i), dq[i], ram[100+i]);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_last", m_last, 0);
        repeat (2) begin
            @(negedge clk); #1;
            if (done) done_seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done || m_valid) done_seen++;
        end
        chk("mid_no_done", done_seen, 0);
        xfer(11'd300, 12'd2, 1'b0);
        chk("post_rst_words", dq.size(), 2);
        chk("post_rst_data0", dq[0], ram[300]);
        chk("post_rst_data1", dq[1], ram[301]);
        chk("post_rst_last", lq[1], 1);

        // full depth
        xfer(11'd5, 12'd2048, 1'b0);
        chk("full_words", dq.size(), 2048);
        chk("full_issues", aq.size(), 2048);
        errs = 0; dup = 0;
        for (int i = 0; i < 2048; i++) seen[i] = 0;
        foreach (aq[i]) begin
            if (seen[aq[i]]) dup++;
            seen[aq[i]] = 1;
        end
        foreach (dq[i]) if (dq[i] !== ram[(5 + i) % 2048]) errs++;
        chk("full_data_err", errs, 0);
        chk("full_addr_dup", dup, 0);
        chk("full_last_cnt", last_count(), 1);
        chk("full_last_pos", lq[2047], 1);
        chk("full_last_data", dq[2047], ram[4]);
        chk("full_last_hs", last_hs, 2050);
        chk("full_credit", credit_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
